// File: rtl/lift_car_controller.sv
// Per-car SCAN motion/door controller with cycle-counted floor travel and door dwell.
// Optional DOOR_REOPEN_EN: door_obstruct restarts the door dwell.
module lift_car_controller #(
  parameter int unsigned NUM_FLOORS  = 11,
  parameter int unsigned FLOOR_TICKS = 8,
  parameter int unsigned DOOR_TICKS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [3:0]            req_floor,
  input  logic                  door_obstruct,
  output logic [3:0]            liftstate,
  output logic [1:0]            lift_dir,
  output logic                  door_open,
  output logic                  served,
  output logic [3:0]            served_floor,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
  localparam logic [1:0]  DIR_IDLE  = 2'b00;
  localparam logic [1:0]  DIR_UP    = 2'b11;
  localparam logic [1:0]  DIR_DOWN  = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3:0]              floor_d, served_floor_d, nxt_floor;
  logic [1:0]              dir_d;
  logic                    served_d;
  logic                    above_any, below_any, req_ok;
  logic [NUM_FLOORS-1:0]   set_mask, clr_mask, absorb_mask, pending_d;

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [3:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

`ifndef DOOR_REOPEN_EN
  logic unused_obstruct;
  assign unused_obstruct = door_obstruct;
`endif

  // Pending stops strictly above / below the current floor
  always_comb begin
    above_any = 1'b0;
    below_any = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (4'(i) > liftstate)) above_any = 1'b1;
      if (pending[i] && (4'(i) < liftstate)) below_any = 1'b1;
    end
  end

  assign req_ok    = req_valid && (32'(req_floor) < NUM_FLOORS);
  assign set_mask  = req_ok ? onehot(req_floor) : '0;
  assign nxt_floor = (state_q == MOVE_UP) ? liftstate + 4'd1 : liftstate - 4'd1;

  // Next-state, counters and stop bookkeeping
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    floor_d        = liftstate;
    dir_d          = lift_dir;
    served_d       = 1'b0;
    served_floor_d = served_floor;
    clr_mask       = '0;
    absorb_mask    = '0;
    case (state_q)
      IDLE: begin
        dir_d = DIR_IDLE;
        cnt_d = '0;
        if (pending[liftstate]) begin
          state_d        = DOOR;
          clr_mask       = onehot(liftstate);
          served_d       = 1'b1;
          served_floor_d = liftstate;
        end else if (above_any) begin
          state_d = MOVE_UP;
          dir_d   = DIR_UP;
        end else if (below_any) begin
          state_d = MOVE_DOWN;
          dir_d   = DIR_DOWN;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (cnt_q == CW'(FLOOR_TICKS - 1)) begin
          cnt_d   = '0;
          floor_d = nxt_floor;
          // A request for the arrival floor in this very cycle also stops the car
          if (pending[nxt_floor] || (req_valid && (req_floor == nxt_floor))) begin
            state_d        = DOOR;
            clr_mask       = onehot(nxt_floor);
            served_d       = 1'b1;
            served_floor_d = nxt_floor;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DOOR: begin
        absorb_mask = onehot(liftstate);
`ifdef DOOR_REOPEN_EN
        if (door_obstruct) begin
          cnt_d = '0;
        end else
`endif
        if (cnt_q == CW'(DOOR_TICKS - 1)) begin
          cnt_d = '0;
          if (lift_dir == DIR_UP && above_any) begin
            state_d = MOVE_UP;
          end else if (lift_dir == DIR_DOWN && below_any) begin
            state_d = MOVE_DOWN;
          end else if (above_any) begin
            state_d = MOVE_UP;
            dir_d   = DIR_UP;
          end else if (below_any) begin
            state_d = MOVE_DOWN;
            dir_d   = DIR_DOWN;
          end else begin
            state_d = IDLE;
            dir_d   = DIR_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    absorb_mask = absorb_mask | clr_mask;
  end

  assign pending_d = (pending & ~clr_mask) | (set_mask & ~absorb_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      liftstate    <= '0;
      lift_dir     <= DIR_IDLE;
      door_open    <= 1'b0;
      served       <= 1'b0;
      served_floor <= '0;
      pending      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      liftstate    <= floor_d;
      lift_dir     <= dir_d;
      door_open    <= (state_d == DOOR);
      served       <= served_d;
      served_floor <= served_floor_d;
      pending      <= pending_d;
    end
  end

endmodule

// File: tb/tb_lift_car_controller.sv
// Directed self-checking bench for lift_car_controller (default parameters).
module tb_lift_car_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [3:0]  req_floor;
  logic        door_obstruct;
  logic [3:0]  liftstate;
  logic [1:0]  lift_dir;
  logic        door_open;
  logic        served;
  logic [3:0]  served_floor;
  logic [10:0] pending;

  int tests = 0;
  int fails = 0;

  lift_car_controller dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor),
    .door_obstruct(door_obstruct), .liftstate(liftstate), .lift_dir(lift_dir),
    .door_open(door_open), .served(served), .served_floor(served_floor), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [3:0]  rf;
    logic [3:0]  ls;
    logic [1:0]  dir;
    logic        door;
    logic        srv;
    logic [10:0] pend;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_floor = 4'd0;
    door_obstruct = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic request(input logic [3:0] f);
    req_valid = 1'b1;
    req_floor = f;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_serve(input string name, input logic [3:0] f, input int budget);
    for (int i = 0; i < budget && !served; i++) tick();
    check({name, "_seen"}, 32'(served), 32'd1);
    check({name, "_floor"}, 32'(served_floor), 32'(f));
    check({name, "_ls"}, 32'(liftstate), 32'(f));
  endtask

  task automatic wait_close(input int budget);
    for (int i = 0; i < budget && door_open; i++) tick();
    check("door_closed", 32'(door_open), 32'd0);
  endtask

  initial begin
    vecs[0] = '{rv: 1'b1, rf: 4'd12, ls: 4'd0, dir: 2'b00, door: 1'b0, srv: 1'b0, pend: 11'h000};
    vecs[1] = '{rv: 1'b1, rf: 4'd15, ls: 4'd0, dir: 2'b00, door: 1'b0, srv: 1'b0, pend: 11'h000};
    vecs[2] = '{rv: 1'b1, rf: 4'd0,  ls: 4'd0, dir: 2'b00, door: 1'b0, srv: 1'b0, pend: 11'h001};
    vecs[3] = '{rv: 1'b0, rf: 4'd0,  ls: 4'd0, dir: 2'b00, door: 1'b1, srv: 1'b1, pend: 11'h000};
    vecs[4] = '{rv: 1'b1, rf: 4'd0,  ls: 4'd0, dir: 2'b00, door: 1'b1, srv: 1'b0, pend: 11'h000};
    vecs[5] = '{rv: 1'b1, rf: 4'd4,  ls: 4'd0, dir: 2'b00, door: 1'b1, srv: 1'b0, pend: 11'h010};

    // Reset values
    do_reset();
    check("rst_ls", 32'(liftstate), 32'd0);
    check("rst_dir", 32'(lift_dir), 32'd0);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_served", 32'(served), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);

    // Out-of-range requests, door entry from idle, absorbed same-floor request
    for (int i = 0; i < 6; i++) begin
      req_valid = vecs[i].rv;
      req_floor = vecs[i].rf;
      tick();
      check($sformatf("vec%0d_ls", i), 32'(liftstate), 32'(vecs[i].ls));
      check($sformatf("vec%0d_dir", i), 32'(lift_dir), 32'(vecs[i].dir));
      check($sformatf("vec%0d_door", i), 32'(door_open), 32'(vecs[i].door));
      check($sformatf("vec%0d_srv", i), 32'(served), 32'(vecs[i].srv));
      check($sformatf("vec%0d_pend", i), 32'(pending), 32'(vecs[i].pend));
    end
    req_valid = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    check("dwell_last", 32'(door_open), 32'd1);
    tick();
    check("dwell_end", 32'(door_open), 32'd0);
    check("dwell_dir", 32'(lift_dir), 32'd3);
    for (int i = 0; i < 31; i++) tick();
    check("pre4_ls", 32'(liftstate), 32'd3);
    check("pre4_srv", 32'(served), 32'd0);
    tick();
    check("arr4_ls", 32'(liftstate), 32'd4);
    check("arr4_srv", 32'(served), 32'd1);
    check("arr4_sf", 32'(served_floor), 32'd4);
    check("arr4_pend", 32'(pending), 32'd0);
    // Request for the floor the door is open at is absorbed
    request(4'd4);
    check("t5_pend", 32'(pending), 32'd0);
    check("t5_srv", 32'(served), 32'd0);
    check("t5_door", 32'(door_open), 32'd1);

    // T2: idle at 0, request floor 3
    do_reset();
    request(4'd3);
    check("t2_pend", 32'(pending), 32'h008);
    tick();
    check("t2_dir", 32'(lift_dir), 32'd3);
    for (int i = 0; i < 23; i++) tick();
    check("t2_pre_ls", 32'(liftstate), 32'd2);
    check("t2_pre_srv", 32'(served), 32'd0);
    tick();
    check("t2_ls", 32'(liftstate), 32'd3);
    check("t2_srv", 32'(served), 32'd1);
    check("t2_sf", 32'(served_floor), 32'd3);
    check("t2_door", 32'(door_open), 32'd1);
    tick();
    check("t2_srv_pulse", 32'(served), 32'd0);
    for (int i = 0; i < 14; i++) tick();
    check("t2_door_last", 32'(door_open), 32'd1);
    tick();
    check("t2_door_off", 32'(door_open), 32'd0);
    check("t2_dir_idle", 32'(lift_dir), 32'd0);

    // T3: SCAN ordering 5 -> 7 -> 9 -> 2
    do_reset();
    request(4'd5);
    wait_serve("t3_s5", 4'd5, 80);
    request(4'd9);
    wait_close(40);
    for (int i = 0; i < 4; i++) tick();
    check("t3_dir_up", 32'(lift_dir), 32'd3);
    request(4'd7);
    request(4'd2);
    check("t3_pend", 32'(pending), 32'h284);
    wait_serve("t3_s7", 4'd7, 60);
    check("t3_s7_dir", 32'(lift_dir), 32'd3);
    tick();
    wait_serve("t3_s9", 4'd9, 80);
    tick();
    wait_serve("t3_s2", 4'd2, 120);
    check("t3_s2_dir", 32'(lift_dir), 32'd2);
    wait_close(40);
    check("t3_idle_dir", 32'(lift_dir), 32'd0);
    check("t3_idle_pend", 32'(pending), 32'd0);

    // T1: asynchronous reset while moving up
    do_reset();
    request(4'd8);
    for (int i = 0; i < 5; i++) tick();
    check("t1_moving", 32'(lift_dir), 32'd3);
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_ls", 32'(liftstate), 32'd0);
    check("t1_dir", 32'(lift_dir), 32'd0);
    check("t1_pend", 32'(pending), 32'd0);
    check("t1_door", 32'(door_open), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t1_idle_dir", 32'(lift_dir), 32'd0);
    check("t1_idle_ls", 32'(liftstate), 32'd0);

    // T6: obstruction in mid-dwell
    do_reset();
    request(4'd0);
    tick();
    check("t6_door", 32'(door_open), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    door_obstruct = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    door_obstruct = 1'b0;
    begin
`ifdef DOOR_REOPEN_EN
      int n = 16;
`else
      int n = 2;
`endif
      for (int i = 0; i < n - 1; i++) tick();
      check("t6_still_open", 32'(door_open), 32'd1);
      tick();
      check("t6_closed", 32'(door_open), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
